// File: rtl/motoro3_commutation_seq_if.sv
// Bus between the commutation sequencer and its controller.
// MOTORO3_COMM_STALL_EN adds the stall flag.
interface motoro3_commutation_seq_if #(
  parameter int STEP_W = 16
);
  // Control inputs are level-sampled on each falling clk edge; stepNow is a
  // one-cycle strobe; every status output is registered.
  logic              run;
  logic              dir;
  logic [STEP_W-1:0] stepPeriod;
  logic              stepNow;
  logic [2:0]        phaseEnable;
  logic [2:0]        phaseH1L0;
  logic [2:0]        step;
  logic              stepTick;
  logic [1:0]        state_dbg;
`ifdef MOTORO3_COMM_STALL_EN
  logic              stall;

  modport master (
    output run, dir, stepPeriod, stepNow,
    input  phaseEnable, phaseH1L0, step, stepTick, state_dbg, stall
  );
  modport slave (
    input  run, dir, stepPeriod, stepNow,
    output phaseEnable, phaseH1L0, step, stepTick, state_dbg, stall
  );
`else
  modport master (
    output run, dir, stepPeriod, stepNow,
    input  phaseEnable, phaseH1L0, step, stepTick, state_dbg
  );
  modport slave (
    input  run, dir, stepPeriod, stepNow,
    output phaseEnable, phaseH1L0, step, stepTick, state_dbg
  );
`endif
endinterface

// File: rtl/motoro3_commutation_seq.sv
// Six-step trapezoidal commutation sequencer with a dead-time window on every step change.
// MOTORO3_COMM_STALL_EN adds a STALL state that is entered when a step never advances.
module motoro3_commutation_seq #(
  parameter int STEP_W   = 16,
  parameter int DEAD_CYC = 8
) (
  input logic                     clk,
  input logic                     nRst,
  motoro3_commutation_seq_if.slave bus
);
  localparam int DW = $clog2(DEAD_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DEAD  = 2'd1,
    S_DRIVE = 2'd2,
    S_STALL = 2'd3
  } state_t;

  state_t            r_state;
  logic [DW-1:0]     r_dead_cnt;
  logic [STEP_W-1:0] r_period_cnt;
  logic [2:0]        r_step;
  logic [2:0]        r_en;
  logic [2:0]        r_h;
  logic              r_tick;
`ifdef MOTORO3_COMM_STALL_EN
  localparam logic [STEP_W-1:0] STALL_AT = {{(STEP_W-1){1'b1}}, 1'b0};
  logic              r_stall;
  assign bus.stall = r_stall;
`endif

  logic       w_expire;
  logic       w_advance;
  logic [2:0] w_step_next;
  logic [2:0] w_drv_en;
  logic [2:0] w_drv_h;

  // Period is compared live, so a shrink below the count waits for the wrap.
  assign w_expire  = (bus.stepPeriod != '0) && (r_period_cnt == bus.stepPeriod - STEP_W'(1));
  assign w_advance = w_expire || bus.stepNow;

  always_comb begin
    w_step_next = r_step;
    if (bus.dir) w_step_next = (r_step == 3'd5) ? 3'd0 : r_step + 3'd1;
    else         w_step_next = (r_step == 3'd0) ? 3'd5 : r_step - 3'd1;
  end

  always_comb begin
    w_drv_en = 3'b000;
    w_drv_h  = 3'b000;
    case (r_step)
      3'd0: begin w_drv_en = 3'b011; w_drv_h = 3'b001; end
      3'd1: begin w_drv_en = 3'b101; w_drv_h = 3'b001; end
      3'd2: begin w_drv_en = 3'b110; w_drv_h = 3'b010; end
      3'd3: begin w_drv_en = 3'b011; w_drv_h = 3'b010; end
      3'd4: begin w_drv_en = 3'b101; w_drv_h = 3'b100; end
      3'd5: begin w_drv_en = 3'b110; w_drv_h = 3'b100; end
      default: begin w_drv_en = 3'b000; w_drv_h = 3'b000; end
    endcase
  end

  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state      <= S_IDLE;
      r_dead_cnt   <= '0;
      r_period_cnt <= '0;
      r_step       <= 3'd0;
      r_en         <= 3'b000;
      r_h          <= 3'b000;
      r_tick       <= 1'b0;
`ifdef MOTORO3_COMM_STALL_EN
      r_stall      <= 1'b0;
`endif
    end else begin
      r_tick <= 1'b0;
      if (!bus.run) begin
        r_state <= S_IDLE;
        r_en    <= 3'b000;
        r_h     <= 3'b000;
`ifdef MOTORO3_COMM_STALL_EN
        r_stall <= 1'b0;
`endif
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state    <= S_DEAD;
            r_dead_cnt <= DW'(DEAD_CYC);
            r_en       <= 3'b000;
            r_h        <= 3'b000;
          end
          S_DEAD: begin
            // Outputs switch to the table only once the window has fully elapsed.
            if (r_dead_cnt == DW'(1)) begin
              r_state      <= S_DRIVE;
              r_period_cnt <= '0;
              r_en         <= w_drv_en;
              r_h          <= w_drv_h;
            end else begin
              r_dead_cnt <= r_dead_cnt - DW'(1);
            end
          end
          S_DRIVE: begin
            if (w_advance) begin
              r_state    <= S_DEAD;
              r_dead_cnt <= DW'(DEAD_CYC);
              r_step     <= w_step_next;
              r_tick     <= 1'b1;
              r_en       <= 3'b000;
              r_h        <= 3'b000;
`ifdef MOTORO3_COMM_STALL_EN
            end else if (r_period_cnt == STALL_AT) begin
              r_state <= S_STALL;
              r_stall <= 1'b1;
              r_en    <= 3'b000;
              r_h     <= 3'b000;
`endif
            end else begin
              r_period_cnt <= r_period_cnt + STEP_W'(1);
            end
          end
          S_STALL: begin
            r_en <= 3'b000;
            r_h  <= 3'b000;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.phaseEnable = r_en;
  assign bus.phaseH1L0   = r_h;
  assign bus.step        = r_step;
  assign bus.stepTick    = r_tick;
  assign bus.state_dbg   = r_state;
endmodule

// File: doc/motoro3_commutation_seq.md
Name: motoro3_commutation_seq

Overview:
- Six-step (trapezoidal) commutation sequencer for the 3-phase bridge.
- Drives the per-phase MOS driver controls (enable, high/low select) for phases A/B/C.
- Inserts a bridge-wide dead-time window on every step change.
- Step advance comes from an internal programmable period counter or an external commutation pulse (hall/BEMF logic).

Parameters:
- STEP_W, 16: width of the step-period counter and the stepPeriod input.
- DEAD_CYC, 8: dead-time length in clk cycles (min 1); all phases disabled for this window.

Ports:
- clk  input  1  10 MHz system clock; all logic on falling edge.
- nRst  input  1  reset, asynchronous, active-low.
- run  input  1  1 = commutate; 0 = stop, bridge off.
- dir  input  1  1 = forward (step+1 mod 6); 0 = reverse (step-1 mod 6).
- stepPeriod  input  STEP_W  DRIVE cycles per step; 0 = internal advance disabled.
- stepNow  input  1  one-cycle external advance request.
- phaseEnable  output  3  [0]=A,[1]=B,[2]=C; to the driver enable input.
- phaseH1L0  output  3  1 = high-side, 0 = low-side, per phase.
- step  output  3  current step index, 0..5.
- stepTick  output  1  one-cycle pulse on each step advance.

Behaviour:
- Reset: phaseEnable=000, phaseH1L0=000, step=0, stepTick=0, state IDLE, both counters 0. All outputs are registered.
- Step table, as high / low / off:
  - 0: A / B / C
  - 1: A / C / B
  - 2: B / C / A
  - 3: B / A / C
  - 4: C / A / B
  - 5: C / B / A
  - Off phase: enable=0, H1L0=0. Low phase: enable=1, H1L0=0. High phase: enable=1, H1L0=1.
- IDLE:
  - Outputs are 0 and step holds its value.
  - run=1 sampled → DEAD; dead counter loaded with DEAD_CYC.
- DEAD:
  - phaseEnable=000 and phaseH1L0=000.
  - Dead counter decrements each cycle; at 1 → DRIVE, and the period counter is cleared.
  - stepNow is ignored in DEAD.
- DRIVE:
  - Outputs follow the table entry for `step`.
  - The period counter increments each cycle.
  - Advance condition: (stepPeriod≠0 AND counter==stepPeriod-1) OR stepNow.
  - On advance: step updates per dir with wrap (5→0 forward, 0→5 reverse), stepTick=1 for one cycle, → DEAD.
- Step length: DEAD_CYC + stepPeriod cycles with internal advance only.
- Simultaneous stepNow and period expiry: exactly one advance.
- A dir change takes effect at the next advance only; the current step is not altered.
- A stepPeriod change mid-step is compared live:
  - New value ≤ counter: no internal advance until the counter wraps at 2^STEP_W.
  - The counter wraps modulo 2^STEP_W.
- run=0 in any state → IDLE on the next edge with outputs 000; step retained. A restart always enters via DEAD.
- nRst assertion mid-operation: immediate outputs 000 and step=0, regardless of clk.
- Shoot-through invariant: a phase's H1L0 never changes while its enable=1 within one step. Transitions always pass through a full DEAD window.

Optional Feature:
- Macro: MOTORO3_COMM_STALL_EN.
- Defined:
  - Adds output `stall` (1 bit, reset 0) and a STALL state.
  - If DRIVE remains in one step for 2^STEP_W-1 cycles without advancing, → STALL: outputs 000, stall=1.
  - Exit STALL only when run=0, which goes to IDLE and clears stall.
- Not defined: no stall port or state; DRIVE may hold indefinitely.

Test Plan:
- Reset release, run=0 → all outputs 0 and step=0 for 50 cycles. Assert nRst mid-DRIVE → outputs 000 asynchronously, before the next clk edge.
- DEAD_CYC=4, stepPeriod=10, dir=1, run=1 → 4 cycles 000, then step0 (phaseEnable=011, phaseH1L0=001) for 10 cycles. stepTick pulses, then 4 cycles 000, then step1 (enable=101, H1L0=001).
  - Sequence continues 0..5→0; step length is 14 cycles.
- dir=0 from step0 → next step is 5 (enable=110, H1L0=100). Toggle dir mid-step2 → the current step completes unchanged, then step 1.
- stepPeriod=0, stepNow pulses 30 cycles apart → one advance per pulse. stepNow during DEAD → ignored. stepNow coinciding with counter==stepPeriod-1 → single advance (step+1, not +2).
- Drop run mid-DRIVE at step3 → outputs 000 on the next edge. Re-raise run → DEAD (4 cycles), then resumes at step3.
- Every cycle of all runs, checker asserts no phase's H1L0 toggles while its enable=1. With MOTORO3_COMM_STALL_EN, STEP_W=8, stepPeriod=0, no stepNow → stall=1 after 255 DRIVE cycles, outputs 000; run=0 clears stall.
